// File: rtl/uart_tx_engine.sv
// UART transmit engine: start, 5..MAX_DATA_BITS data bits LSB first, optional parity,
// one or two stop bits, and a line-break mode. Bit period is clk_div_i+1 clock cycles.
module uart_tx_engine #(
    parameter int DIV_WIDTH     = 32,
    parameter int MAX_DATA_BITS = 9
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clk_en_i,
    input  logic [DIV_WIDTH-1:0]     clk_div_i,
    input  logic [3:0]               data_bits_i,
    input  logic [2:0]               parity_mode_i,
    input  logic                     extra_stop_i,
    input  logic                     break_i,
    input  logic [MAX_DATA_BITS-1:0] tx_data_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    localparam logic [3:0]           MIN_N   = 4'd5;
    localparam logic [3:0]           MAX_N   = 4'(MAX_DATA_BITS);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

    state_e                   state_q;
    logic [DIV_WIDTH-1:0]     cnt_q;
    logic [DIV_WIDTH-1:0]     div_q;
    logic [MAX_DATA_BITS-1:0] shift_q;
    logic [3:0]               nbits_q;
    logic [3:0]               bit_idx_q;
    logic                     par_en_q;
    logic                     par_bit_q;
    logic                     extra_q;
    logic                     stop_left_q;
    logic                     brk_stop_q;
    logic                     tx_q;
    logic                     done_q;

    logic [3:0]               nbits_d;
    logic [MAX_DATA_BITS-1:0] data_d;
    logic                     par_en_d;
    logic                     par_bit_d;
    logic                     handshake;
    logic                     bit_end;
    logic                     next_last;

    assign tx_ready_o = (state_q == S_IDLE) && clk_en_i && !break_i && !rst_i;
    assign handshake  = tx_valid_i && tx_ready_o;
    assign bit_end    = (cnt_q == div_q);
    // True when the coming cycle is the final cycle of a bit period.
    assign next_last  = bit_end ? (div_q == '0) : ((cnt_q + CNT_ONE) == div_q);

    assign tx_o   = tx_q;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;

    always_comb begin
        nbits_d = data_bits_i;
        if (data_bits_i < MIN_N) begin
            nbits_d = MIN_N;
        end else if (data_bits_i > MAX_N) begin
            nbits_d = MAX_N;
        end
        data_d = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            data_d[i] = tx_data_i[i] && (i < int'(nbits_d));
        end
        par_en_d  = 1'b1;
        par_bit_d = ^data_d;
        case (parity_mode_i)
            3'd1:    par_bit_d = ^data_d;
            3'd2:    par_bit_d = ~^data_d;
            3'd3:    par_bit_d = 1'b1;
            3'd4:    par_bit_d = 1'b0;
            default: par_en_d  = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: datapath registers are reset along with the state so an aborted frame leaves nothing stale.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            shift_q     <= '0;
            nbits_q     <= '0;
            bit_idx_q   <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            extra_q     <= 1'b0;
            stop_left_q <= 1'b0;
            brk_stop_q  <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    if (break_i) begin
                        state_q <= S_BREAK;
                        tx_q    <= 1'b0;
                    end else if (handshake) begin
                        state_q   <= S_START;
                        tx_q      <= 1'b0;
                        div_q     <= clk_div_i;
                        shift_q   <= data_d;
                        nbits_q   <= nbits_d;
                        par_en_q  <= par_en_d;
                        par_bit_q <= par_bit_d;
                        extra_q   <= extra_stop_i;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= 4'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == nbits_q) begin
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q     <= S_STOP;
                                tx_q        <= 1'b1;
                                stop_left_q <= extra_q;
                                done_q      <= next_last && !extra_q;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_q       <= '0;
                        state_q     <= S_STOP;
                        tx_q        <= 1'b1;
                        stop_left_q <= extra_q;
                        done_q      <= next_last && !extra_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (stop_left_q) begin
                            stop_left_q <= 1'b0;
                            done_q      <= next_last && !brk_stop_q;
                        end else begin
                            state_q    <= S_IDLE;
                            brk_stop_q <= 1'b0;
                        end
                    end else begin
                        cnt_q  <= cnt_q + CNT_ONE;
                        done_q <= next_last && !stop_left_q && !brk_stop_q;
                    end
                end
                S_BREAK: begin
                    tx_q <= 1'b0;
                    // Leaving break: one idle-level bit period through STOP, never flagged as done.
                    if (!break_i) begin
                        state_q     <= S_STOP;
                        tx_q        <= 1'b1;
                        div_q       <= clk_div_i;
                        cnt_q       <= '0;
                        stop_left_q <= 1'b0;
                        brk_stop_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: each frame's expected line waveform is built as a
// per-cycle bit queue from the frame rules and compared cycle by cycle.
module tb_uart_tx_engine;

    localparam int TB_DIV_W = 8;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic                clk_en_i = 1'b1;
    logic [TB_DIV_W-1:0] clk_div_i = '0;
    logic [3:0]          data_bits_i = 4'd8;
    logic [2:0]          parity_mode_i = 3'd0;
    logic                extra_stop_i = 1'b0;
    logic                break_i = 1'b0;
    logic [8:0]          tx_data_i = '0;
    logic                tx_valid_i = 1'b0;
    logic                tx_ready_o;
    logic                tx_o;
    logic                busy_o;
    logic                done_o;

    int vectors = 0;
    int miscompares = 0;
    bit exp_q[$];

    uart_tx_engine #(
        .DIV_WIDTH    (TB_DIV_W),
        .MAX_DATA_BITS(9)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .clk_en_i     (clk_en_i),
        .clk_div_i    (clk_div_i),
        .data_bits_i  (data_bits_i),
        .parity_mode_i(parity_mode_i),
        .extra_stop_i (extra_stop_i),
        .break_i      (break_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Reference: start, clamped data bits, optional parity, stops; each bit held d+1 cycles.
    task automatic build_expected(input logic [8:0] data, input int d, input int nb,
                                  input int pm, input bit es);
        int n;
        int ones;
        bit bits[$];
        n = (nb < 5) ? 5 : ((nb > 9) ? 9 : nb);
        ones = 0;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        case (pm)
            1: bits.push_back(bit'(ones % 2));
            2: bits.push_back(!bit'(ones % 2));
            3: bits.push_back(1'b1);
            4: bits.push_back(1'b0);
            default: ;
        endcase
        bits.push_back(1'b1);
        if (es) bits.push_back(1'b1);
        exp_q = {};
        foreach (bits[j]) repeat (d + 1) exp_q.push_back(bits[j]);
    endtask

    // Handshake in the current cycle, then follow the whole frame; optionally
    // scramble every input after the handshake to prove the frame is latched.
    task automatic run_frame(input logic [8:0] data, input int d, input int nb, input int pm,
                             input bit es, input bit scramble, input string name);
        logic [3:0] got_v;
        logic [3:0] exp_v;
        build_expected(data, d, nb, pm, es);
        @(negedge clk);
        rst_i = 1'b0;
        tx_data_i = data;
        clk_div_i = d[TB_DIV_W-1:0];
        data_bits_i = nb[3:0];
        parity_mode_i = pm[2:0];
        extra_stop_i = es;
        break_i = 1'b0;
        clk_en_i = 1'b1;
        tx_valid_i = 1'b1;
        #1;
        got_v = {tx_o, busy_o, done_o, tx_ready_o};
        vectors++;
        if (got_v !== 4'b1001) begin
            miscompares++;
            $display("FAIL %s handshake: tx/busy/done/ready=%b expected 1001", name, got_v);
        end
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            tx_valid_i = 1'b0;
            if (scramble) begin
                tx_data_i = 9'($urandom);
                clk_div_i = TB_DIV_W'($urandom);
                data_bits_i = 4'($urandom);
                parity_mode_i = 3'($urandom);
                extra_stop_i = 1'($urandom);
                tx_valid_i = 1'($urandom);
                clk_en_i = 1'($urandom);
                break_i = 1'($urandom);
            end
            #1;
            got_v = {tx_o, busy_o, done_o, tx_ready_o};
            exp_v = {exp_q[k-1], 1'b1, (k == exp_q.size()), 1'b0};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle T+%0d: tx/busy/done/ready=%b expected %b",
                         name, k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] got_v;
        rst_i = 1'b1;
        clk_en_i = 1'b1;
        tx_valid_i = 1'b1;
        break_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        got_v = {tx_o, busy_o, done_o, tx_ready_o};
        vectors++;
        if (got_v !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_state: tx/busy/done/ready=%b expected 1000", got_v);
        end
    endtask

    task automatic test_directed();
        run_frame(9'h055, 3, 8, 0, 1'b0, 1'b0, "8N1_d3_0x55");
        run_frame(9'h041, 0, 7, 2, 1'b1, 1'b0, "7O2_d0_0x41");
        run_frame(9'h1FF, 1, 9, 1, 1'b0, 1'b1, "9E1_d1_latched");
        run_frame(9'h0FF, 0, 3, 0, 1'b0, 1'b0, "len3_clamped_to_5");
        run_frame(9'h1FF, 0, 15, 4, 1'b1, 1'b0, "len15_clamped_to_9_space");
        run_frame(9'h015, 255, 5, 3, 1'b0, 1'b0, "divider_all_ones_mark");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_frame(9'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), "random_frame");
        end
    endtask

    task automatic test_clk_en();
        logic [3:0] got_v;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst_i = 1'b0;
            break_i = 1'b0;
            clk_en_i = (k == 3);
            tx_valid_i = (k != 3);
            tx_data_i = 9'($urandom);
            #1;
            got_v = {tx_o, busy_o, done_o, tx_ready_o};
            vectors++;
            if (got_v !== {3'b100, (k == 3)}) begin
                miscompares++;
                $display("FAIL clk_en_gate step %0d: tx/busy/done/ready=%b expected %b",
                         k, got_v, {3'b100, (k == 3)});
            end
        end
    endtask

    task automatic test_break(input int d, input string name);
        logic [3:0] got_v;
        logic [3:0] exp_v;
        @(negedge clk);
        rst_i = 1'b0;
        break_i = 1'b1;
        clk_en_i = 1'b1;
        tx_valid_i = 1'b1;
        clk_div_i = TB_DIV_W'($urandom);
        #1;
        got_v = {tx_o, busy_o, done_o, tx_ready_o};
        vectors++;
        if (got_v !== 4'b1000) begin
            miscompares++;
            $display("FAIL %s request: tx/busy/done/ready=%b expected 1000", name, got_v);
        end
        for (int k = 1; k <= 22 + d; k++) begin
            @(negedge clk);
            if (k < 20) begin
                break_i = 1'b1;
                clk_div_i = TB_DIV_W'($urandom);
                tx_valid_i = 1'($urandom);
            end else if (k == 20) begin
                break_i = 1'b0;
                clk_div_i = d[TB_DIV_W-1:0];
                tx_valid_i = 1'b0;
            end else if (k < 22 + d) begin
                break_i = 1'($urandom);
                clk_div_i = TB_DIV_W'($urandom);
                tx_valid_i = 1'($urandom);
            end else begin
                break_i = 1'b0;
                tx_valid_i = 1'b0;
            end
            #1;
            got_v = {tx_o, busy_o, done_o, tx_ready_o};
            if (k <= 20) exp_v = 4'b0100;
            else if (k <= 21 + d) exp_v = 4'b1100;
            else exp_v = 4'b1001;
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle B+%0d: tx/busy/done/ready=%b expected %b",
                         name, k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] got_v;
        logic [3:0] exp_v;
        logic [8:0] data;
        data = 9'($urandom);
        build_expected(data, 3, 8, 0, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        tx_data_i = data;
        clk_div_i = 8'd3;
        data_bits_i = 4'd8;
        parity_mode_i = 3'd0;
        extra_stop_i = 1'b0;
        break_i = 1'b0;
        clk_en_i = 1'b1;
        tx_valid_i = 1'b1;
        #1;
        got_v = {tx_o, busy_o, done_o, tx_ready_o};
        vectors++;
        if (got_v !== 4'b1001) begin
            miscompares++;
            $display("FAIL abort handshake: tx/busy/done/ready=%b expected 1001", got_v);
        end
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            tx_valid_i = 1'b0;
            rst_i = (k == 10);
            #1;
            got_v = {tx_o, busy_o, done_o, tx_ready_o};
            exp_v = (k <= 10) ? {exp_q[k-1], 3'b100} : 4'b1001;
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL abort cycle T+%0d: tx/busy/done/ready=%b expected %b",
                         k, got_v, exp_v);
            end
        end
        run_frame(9'($urandom), 3, 8, 0, 1'b0, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_clk_en();
        test_break(4, "break_d4");
        test_break(0, "break_d0");
        test_break(int'($urandom_range(1, 6)), "break_rand");
        run_frame(9'($urandom), 2, 6, 1, 1'b1, 1'b1, "after_break");
        test_reset_mid_frame();
        test_clk_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter DIV_WIDTH, default 32: width of the bit-period divider.
REQ-002 Parameter MAX_DATA_BITS, default 9, legal range 5..9: widest character supported.
REQ-003 clk_i  input  1: the single clock; all logic on rising edge.
REQ-004 rst_i  input  1: synchronous, active-high reset.
REQ-005 clk_en_i  input  1: enables acceptance of new characters.
REQ-006 clk_div_i  input  DIV_WIDTH: bit period is clk_div_i+1 cycles.
REQ-007 data_bits_i  input  4: character length, 5..MAX_DATA_BITS.
REQ-008 parity_mode_i  input  3: 0 none, 1 even, 2 odd, 3 mark (1), 4 space (0); 5..7 treated as none.
REQ-009 extra_stop_i  input  1: 0 = one stop bit, 1 = two stop bits.
REQ-010 break_i  input  1: request line-break (tx_o held low).
REQ-011 tx_data_i  input  MAX_DATA_BITS: character, LSB first; bits at or above data_bits_i ignored.
REQ-012 tx_valid_i  input  1 / tx_ready_o  output  1: valid/ready handshake for tx_data_i.
REQ-013 tx_o  output  1: serial line, idle high.
REQ-014 busy_o  output  1: high in every state except IDLE.
REQ-015 done_o  output  1: one-cycle pulse on the final cycle of the last stop bit.

Function
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-017 tx_ready_o SHALL equal (state==IDLE) && clk_en_i && !break_i, combinationally.
REQ-018 Handshake occurs in cycle T when tx_valid_i && tx_ready_o; the block SHALL latch data, clk_div_i, data_bits_i, parity_mode_i, extra_stop_i in T; later input changes have no effect on that frame.
REQ-019 data_bits_i below 5 SHALL be latched as 5; above MAX_DATA_BITS as MAX_DATA_BITS.
REQ-020 From cycle T+1, tx_o SHALL be 0 for D+1 cycles (START), D = latched divider.
REQ-021 DATA SHALL drive N bits LSB first, each D+1 cycles, N = latched length.
REQ-022 PARITY state SHALL be entered only if mode 1..4; even: XOR of N data bits, odd: its inverse, mark: 1, space: 0; D+1 cycles.
REQ-023 STOP SHALL drive tx_o=1 for (1+extra_stop)*(D+1) cycles.
REQ-024 Frame length SHALL be exactly (1+N+P+S)*(D+1) cycles, P in {0,1}, S in {1,2}; done_o asserted in its last cycle, IDLE the following cycle.
REQ-025 clk_div_i=0 SHALL yield one cycle per bit; divider counter SHALL not wrap or skip at all-ones (2^DIV_WIDTH cycles per bit).
REQ-026 clk_en_i deassertion mid-frame SHALL NOT stall or abort the frame; it only blocks new handshakes.
REQ-027 break_i in IDLE SHALL enter BREAK (tx_o=0) next cycle; break_i is ignored outside IDLE until the frame ends.
REQ-028 On break_i falling in BREAK, the block SHALL drive tx_o=1 for one bit period (clk_div_i sampled at that edge, +1 cycles) via STOP without done_o, then IDLE.
REQ-029 Minimum gap between back-to-back frames SHALL be one IDLE cycle with tx_o=1.
REQ-030 tx_valid_i while tx_ready_o=0 SHALL be ignored; tx_data_i need not be held.

Reset
REQ-031 While rst_i is high, on the next edge: state IDLE, tx_o=1, busy_o=0, done_o=0, tx_ready_o=0, all counters 0.
REQ-032 rst_i mid-frame SHALL abort immediately; tx_o=1 the next cycle; no done_o.
REQ-033 The first handshake after reset SHALL be possible in the cycle after rst_i falls.

Verification
REQ-034 D=3, 8 bits, none, 1 stop, data 0x55 -> tx_o 0,1,0,1,0,1,0,1,0,1 each 4 cycles from T+1; done_o at T+40; tx_ready_o high T+41.
REQ-035 D=0, 7 bits, odd, 2 stop, data 0x41 -> tx_o 0,1,0,0,0,0,0,1,1,1,1 one cycle each; parity bit 1; done_o at T+11.
REQ-036 D=1, 9 bits, even, data 0x1FF, clk_div_i changed to 9 at T+3 -> 9 ones, parity 1, total 24 cycles, all bits 2 cycles.
REQ-037 break_i high 20 cycles in IDLE, D=4 -> tx_o low 20 cycles, then high 5 cycles, busy_o throughout, no done_o, tx_ready_o after.
REQ-038 rst_i at T+10 of an 8N1 frame, D=3 -> tx_o=1, busy_o=0 at T+11; no done_o; new handshake at T+12 transmits normally.
REQ-039 data_bits_i=3 with data 0xFF, D=0, none -> latched as 5: 0,1,1,1,1,1,1, done_o at T+7.
